// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared memory line port between the I-cache miss port and the
// D-cache miss/writeback port, one whole line transaction at a time.
module cache_mem_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RELEASE
    } state_t;

    state_t state;
    logic   last_grant;
    logic   d_pending;

    assign d_pending = d_read | d_write;

    // last_grant == 0 means I was served last, so a tie goes to D.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_read && d_pending) begin
                        if (!last_grant) begin
                            state      <= SERVE_D;
                            last_grant <= 1'b1;
                        end else begin
                            state      <= SERVE_I;
                            last_grant <= 1'b0;
                        end
                    end else if (i_read) begin
                        state      <= SERVE_I;
                        last_grant <= 1'b0;
                    end else if (d_pending) begin
                        state      <= SERVE_D;
                        last_grant <= 1'b1;
                    end
                end
                SERVE_I: if (mem_resp) state <= RELEASE;
                SERVE_D: if (mem_resp) state <= RELEASE;
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Commands come from the registered grant plus the held request lines.
    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (state)
            SERVE_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
                i_resp      = mem_resp;
            end
            SERVE_D: begin
                mem_read    = d_read & ~d_write;
                mem_write   = d_write;
                mem_address = d_address;
                mem_wdata   = d_wdata;
                d_resp      = mem_resp;
            end
            default: ;
        endcase
    end

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       i_rd;
        logic       d_rd;
        logic       d_wr;
        logic       m_resp;
        logic       e_read;
        logic       e_write;
        logic       e_iresp;
        logic       e_dresp;
        logic [1:0] e_sel;   // 0 nobody, 1 I-cache, 2 D-cache drives the memory port
    } vec_t;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctrl"}, LW'({mem_read, mem_write, i_resp, d_resp}), '0);
        check({name, "_addr"}, LW'(mem_address), '0);
        check({name, "_wdata"}, mem_wdata, '0);
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        cyc();
        cyc();
        @(negedge clk);
        check_quiet("reset");
        reset = 0;
        cyc();
    endtask

    // Transaction-level reference: who owns the port, whether the one-cycle
    // gap is pending, and whether the next tie should go to D.
    int   owner;
    bit   gap;
    bit   tie_to_d;
    logic e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd;

    task automatic model_outputs();
        e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = '0; e_wd = '0;
        if (owner == 1) begin
            e_rd = 1; e_addr = i_address; e_ir = mem_resp;
        end else if (owner == 2) begin
            e_wr = d_write; e_rd = d_read & ~d_write;
            e_addr = d_address; e_wd = d_wdata; e_dr = mem_resp;
        end
    endtask

    task automatic model_edge();
        bit iw, dw;
        iw = i_read;
        dw = d_read | d_write;
        if (reset) begin
            owner = 0; gap = 0; tie_to_d = 1;
        end else if (owner != 0) begin
            if (mem_resp) begin owner = 0; gap = 1; end
        end else if (gap) begin
            gap = 0;
        end else begin
            if (iw && dw) owner = tie_to_d ? 2 : 1;
            else if (iw) owner = 1;
            else if (dw) owner = 2;
            if (owner != 0) tie_to_d = (owner == 1);
        end
    endtask

    vec_t vecs[26];
    logic [LW-1:0] pat;
    logic [LW-1:0] line_a5;

    initial begin
        int svc, n, cycles, kind;
        bit rst_now, exp_ir, exp_dr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ew;

        reset = 1;
        clear_inputs();
        pat = {8{32'hC0DE_1234}};
        line_a5 = {(LW / 8){8'hA5}};

        //        i  d  w  r    rd wr ir dr sel
        vecs[0]  = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 0, 0,  1, 0, 0, 0, 2};
        vecs[2]  = '{1, 1, 0, 1,  1, 0, 0, 1, 2};
        vecs[3]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0,  1, 0, 0, 0, 1};
        vecs[6]  = '{1, 0, 0, 1,  1, 0, 1, 0, 1};
        vecs[7]  = '{0, 0, 1, 0,  0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 1, 0,  0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0,  0, 1, 0, 0, 2};
        vecs[10] = '{0, 0, 1, 1,  0, 1, 0, 1, 2};
        vecs[11] = '{0, 1, 1, 0,  0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 1, 0,  0, 0, 0, 0, 0};
        vecs[13] = '{0, 1, 1, 0,  0, 1, 0, 0, 2};
        vecs[14] = '{0, 1, 1, 1,  0, 1, 0, 1, 2};
        vecs[15] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        vecs[17] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[18] = '{1, 1, 0, 0,  0, 0, 0, 0, 0};
        vecs[19] = '{1, 1, 0, 0,  1, 0, 0, 0, 1};
        vecs[20] = '{1, 1, 0, 1,  1, 0, 1, 0, 1};
        vecs[21] = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
        vecs[22] = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
        vecs[23] = '{0, 1, 0, 0,  1, 0, 0, 0, 2};
        vecs[24] = '{0, 1, 0, 1,  1, 0, 0, 1, 2};
        vecs[25] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};

        // Vector table: tie after reset, turnaround, writeback, illegal r+w, stray resp.
        do_reset();
        for (int v = 0; v < 26; v++) begin
            i_read = vecs[v].i_rd; d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
            mem_resp = vecs[v].m_resp;
            i_address = 32'h0000_0060; d_address = 32'h0000_1000; d_wdata = pat;
            mem_rdata = rand_line();
            ea = (vecs[v].e_sel == 2'd1) ? 32'h60 : (vecs[v].e_sel == 2'd2) ? 32'h1000 : 32'h0;
            ew = (vecs[v].e_sel == 2'd2) ? pat : '0;
            @(negedge clk);
            check($sformatf("vec%0d_ctrl", v), LW'({mem_read, mem_write, i_resp, d_resp}),
                  LW'({vecs[v].e_read, vecs[v].e_write, vecs[v].e_iresp, vecs[v].e_dresp}));
            check($sformatf("vec%0d_addr", v), LW'(mem_address), LW'(ea));
            check($sformatf("vec%0d_wdata", v), mem_wdata, ew);
            check($sformatf("vec%0d_rdata", v), i_rdata & d_rdata, mem_rdata);
            cyc();
        end
        clear_inputs();

        // I-only read, memory answers in the fifth service cycle.
        do_reset();
        i_read = 1; i_address = 32'h0000_0060;
        @(negedge clk);
        check("ionly_idle_rd", LW'(mem_read), 0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin mem_resp = 1; mem_rdata = line_a5; end
            @(negedge clk);
            check("ionly_rd", LW'(mem_read), 1);
            check("ionly_addr", LW'(mem_address), LW'(32'h60));
            check("ionly_iresp", LW'(i_resp), LW'(k == 4));
            check("ionly_dresp", LW'(d_resp), 0);
            cyc();
        end
        check("ionly_rdata", i_rdata, line_a5);
        mem_resp = 0; i_read = 0;
        @(negedge clk);
        check_quiet("ionly_release");
        cyc();
        @(negedge clk);
        check_quiet("ionly_idle");
        cyc();

        // Reset two cycles into an I service, then a fresh D read.
        do_reset();
        i_read = 1; i_address = 32'h0000_0440;
        cyc();
        @(negedge clk); check("rmid_rd1", LW'(mem_read), 1);
        cyc();
        @(negedge clk); check("rmid_rd2", LW'(mem_read), 1);
        cyc();
        reset = 1;
        cyc();
        reset = 0; i_read = 0; d_read = 1; d_address = 32'h0000_2000;
        @(negedge clk);
        check_quiet("rmid_after");
        cyc();
        mem_resp = 1; mem_rdata = pat;
        @(negedge clk);
        check("rmid_d_rd", LW'(mem_read), 1);
        check("rmid_d_addr", LW'(mem_address), LW'(32'h2000));
        check("rmid_d_resp", LW'({i_resp, d_resp}), LW'(2'b01));
        check("rmid_d_rdata", d_rdata, pat);
        cyc();
        clear_inputs();

        // Sustained contention: grants must alternate D, I, D, I ...
        do_reset();
        i_read = 1; d_read = 1; i_address = 32'h80; d_address = 32'h3000;
        svc = 0; n = 0; cycles = 0;
        while (n < 8 && cycles < 300) begin
            mem_resp = (svc == 2);
            @(negedge clk);
            if (i_resp || d_resp) begin
                check($sformatf("alt_grant%0d", n), LW'({i_resp, d_resp}),
                      LW'((n % 2 == 0) ? 2'b01 : 2'b10));
                n++;
                svc = 0;
            end else if (mem_read || mem_write) svc++;
            else svc = 0;
            cycles++;
            cyc();
        end
        if (n < 8) begin
            checks++; errors++;
            $display("FAIL alt_timeout: got %0d grants expected 8", n);
        end
        clear_inputs();

        // Randomized traffic against the reference model.
        do_reset();
        owner = 0; gap = 0; tie_to_d = 1;
        for (int c = 0; c < 4000; c++) begin
            rst_now = ($urandom_range(0, 99) == 0);
            reset = rst_now;
            mem_resp = (owner != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            mem_rdata = rand_line();
            @(negedge clk);
            model_outputs();
            check("rand_ctrl", LW'({mem_read, mem_write, i_resp, d_resp}), LW'({e_rd, e_wr, e_ir, e_dr}));
            check("rand_addr", LW'(mem_address), LW'(e_addr));
            check("rand_wdata", mem_wdata, e_wd);
            check("rand_rdata", i_rdata & d_rdata, mem_rdata);
            exp_ir = e_ir;
            exp_dr = e_dr;
            model_edge();
            cyc();
            if (rst_now) begin
                i_read = 0; d_read = 0; d_write = 0;
            end else begin
                if (exp_ir || !i_read) begin
                    i_read = $urandom_range(0, 1);
                    i_address = $urandom & 32'hFFFF_FFE0;
                end
                if (exp_dr || !(d_read || d_write)) begin
                    kind = $urandom_range(0, 9);
                    d_read = (kind >= 4 && kind <= 6) || kind == 9;
                    d_write = (kind >= 7);
                    d_address = $urandom & 32'hFFFF_FFE0;
                    d_wdata = rand_line();
                end
            end
        end
        reset = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-cache miss port and the data-cache miss/writeback port.
- Sits below the split caches that serve the cpu's cmem_a and cmem_b interfaces, and above the shared memory (L2 or physical).
- Grants one whole line transaction at a time. Ties between the two requesters are broken round-robin.
- Forwards the granted requester's command and routes the response back only to that requester.

Parameters:
- LINE_WIDTH, 256: bits per cache line transfer.
- ADDR_WIDTH, 32: memory address width.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- i_read, input, 1: I-cache line read request.
- i_address, input, ADDR_WIDTH: I-cache line address.
- i_rdata, output, LINE_WIDTH: line data returned to the I-cache.
- i_resp, output, 1: I-cache transaction complete.
- d_read, input, 1: D-cache line read request.
- d_write, input, 1: D-cache line writeback request.
- d_address, input, ADDR_WIDTH: D-cache line address.
- d_wdata, input, LINE_WIDTH: D-cache writeback line.
- d_rdata, output, LINE_WIDTH: line data returned to the D-cache.
- d_resp, output, 1: D-cache transaction complete.
- mem_read, output, 1: read command to shared memory.
- mem_write, output, 1: write command to shared memory.
- mem_address, output, ADDR_WIDTH: address to shared memory.
- mem_wdata, output, LINE_WIDTH: write line to shared memory.
- mem_rdata, input, LINE_WIDTH: read line from shared memory.
- mem_resp, input, 1: shared memory transaction complete.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, RELEASE. Additional register last_grant (0 = I, 1 = D).
- Reset values: state = IDLE, last_grant = 0. Every output is 0 while in IDLE or RELEASE and in the cycle after reset is asserted. The exception is i_rdata/d_rdata, which are always a direct copy of mem_rdata.
- Request protocol:
  - A requester holds its request and address/data stable until it sees its resp.
  - It may drop the request in the cycle after resp.
  - resp is a single-cycle pulse.
- IDLE transitions:
  - Only i_read pending: go to SERVE_I.
  - Only d_read or d_write pending: go to SERVE_D.
  - Both pending: go to SERVE_D if last_grant = 0, else SERVE_I.
  - Nothing pending: stay in IDLE.
- last_grant updates on entry to SERVE_I/SERVE_D. Grant decision is registered, so a request seen in IDLE at cycle t drives mem_* from cycle t+1.
- SERVE_I:
  - mem_read = 1, mem_write = 0, mem_address = i_address.
  - i_resp = mem_resp, combinational, same cycle. d_resp = 0.
  - On mem_resp, go to RELEASE.
- SERVE_D:
  - mem_read = d_read & ~d_write, mem_write = d_write, mem_address = d_address, mem_wdata = d_wdata.
  - d_resp = mem_resp. i_resp = 0.
  - On mem_resp, go to RELEASE.
  - d_read and d_write together is illegal. The write takes precedence and no read is issued.
- RELEASE:
  - One cycle with all mem commands and resps at 0, so neither memory nor the requester sees a stale command.
  - Always returns to IDLE.
  - Minimum back-to-back turnaround: resp at cycle t, RELEASE at t+1, IDLE at t+2, next command at t+3.
- A request arriving while the other side is being served waits; no preemption.
- mem_resp seen in IDLE or RELEASE is ignored and forwarded to no one.
- Reset asserted mid-transaction: the state returns to IDLE on that edge and the in-flight transaction is abandoned. The memory model is reset alongside, and requesters are reset too.
- mem_address and mem_wdata are 0 in IDLE/RELEASE. mem_wdata is 0 in SERVE_I.
- No combinational path from request inputs to mem_read/mem_write; they depend only on state and the held request lines.

Test Plan:
- I-only read: i_read = 1, addr 0x00000060; memory responds after 5 cycles with line 0xA5..A5 -> mem_read = 1 with addr 0x60 from cycle t+1; i_rdata = 0xA5..A5 with i_resp for one cycle; d_resp stays 0; RELEASE then IDLE.
- Simultaneous requests after reset: i_read and d_read at the same edge -> D served first (last_grant = 0). Then I is served, with the mem command starting 3 cycles after D's resp.
- Alternation under contention: both requesters continuously re-request 4 times each -> grants strictly alternate D, I, D, I..., with no starvation.
- D writeback: d_write = 1, addr 0x00001000, wdata = pattern P -> mem_write = 1, mem_wdata = P, mem_read = 0; d_resp pulses once; an illegal d_read + d_write combination issues a write only.
- Reset mid-transaction: assert reset 2 cycles into SERVE_I -> next cycle mem_read = 0 and all resps = 0, state IDLE. A new d_read is then granted normally.
- Stray mem_resp in IDLE -> no i_resp/d_resp pulse and no state change.
